// File: rtl/cart_bus_pkg.sv
// Shared encodings for the cart bus arbiter: arbitration modes and FSM states.
package cart_bus_pkg;

    localparam int ARB_PHASED = 0;
    localparam int ARB_PRIO   = 1;
    localparam int ARB_RR     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cart_bus_arbiter_if.sv
// Requester-side and cart-side signals of the shared cart bus arbiter.
// Slice i of the packed request vectors belongs to requester i.
interface cart_bus_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    localparam int PH_W = $clog2(N_REQ);

    logic [N_REQ*ADDR_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_din;
    logic [N_REQ-1:0]        req_rd;
    logic [N_REQ-1:0]        req_wr;
    logic [N_REQ-1:0]        req_phase_done;
    logic [N_REQ-1:0]        req_busy;
    logic [N_REQ-1:0]        grant;
    logic [ADDR_W-1:0]       bus_a;
    logic [DATA_W-1:0]       bus_din;
    logic                    bus_rd;
    logic                    bus_wr;
    logic                    bus_busy;
    logic [PH_W-1:0]         phase;

    modport master (
        output req_a, req_din, req_rd, req_wr, req_phase_done, bus_busy,
        input  req_busy, grant, bus_a, bus_din, bus_rd, bus_wr, phase
    );

    modport slave (
        input  req_a, req_din, req_rd, req_wr, req_phase_done, bus_busy,
        output req_busy, grant, bus_a, bus_din, bus_rd, bus_wr, phase
    );

endinterface

// File: rtl/cart_arb_pick.sv
// Combinational winner select: first eligible pending index at or after ptr (wrapping).
// Zero latency; ptr=0 gives plain lowest-index priority.
module cart_arb_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         pend,
    input  logic [N_REQ-1:0]         elig,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     win_vld,
    output logic [N_REQ-1:0]         win_oh,
    output logic [$clog2(N_REQ)-1:0] win_idx
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] cand;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        cand    = pend & elig;
        sum     = '0;
        idx     = '0;
        win_vld = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!win_vld && cand[idx]) begin
                win_vld     = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/cart_bus_arbiter.sv
// Registered N-requester arbiter for the shared cart ROM/RAM port; 2 cycles strobe-to-bus-strobe.
// Owner holds the bus until cart busy falls or times out; other strobes are latched and req_busy held.
module cart_bus_arbiter
    import cart_bus_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MODE    = 0,
    parameter int BUSY_TO = 15
) (
    input  logic               clk_8m,
    input  logic               rst_n,
    cart_bus_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  strb, strb_q, cap;
    logic [N_REQ-1:0]  pend_q, pend_nxt, elig;
    logic [N_REQ-1:0]  grant_q, grant_nxt, busy_q;
    logic [N_REQ-1:0]  pick_oh;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx, owner_q, rr_q, phase_q;
    logic [ADDR_W-1:0] slot_a [N_REQ];
    logic [DATA_W-1:0] slot_d [N_REQ];
    logic [N_REQ-1:0]  slot_rd;
    arb_state_t        state_q, state_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic              issue, done, phase_adv;
    logic [ADDR_W-1:0] bus_a_q;
    logic [DATA_W-1:0] bus_din_q;
    logic              bus_rd_q, bus_wr_q;

    // Only the rising edge of a strobe counts, and only into an empty slot.
    assign strb = bus.req_rd | bus.req_wr;
    assign cap  = strb & ~strb_q & ~pend_q;

    always_comb begin
        elig = '1;
        if (MODE == ARB_PHASED) begin
            elig          = '0;
            elig[phase_q] = 1'b1;
        end
    end

    cart_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .pend    (pend_q),
        .elig    (elig),
        .ptr     (rr_q),
        .win_vld (pick_vld),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        issue     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    issue     = 1'b1;
                    state_nxt = WAIT_HI;
                    cnt_nxt   = 8'd0;
                end
            end
            WAIT_HI: begin
                if (bus.bus_busy) begin
                    state_nxt = WAIT_LO;
                end else if (cnt_q == 8'(BUSY_TO - 1)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!bus.bus_busy) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A phase may only be left when nothing of it is waiting or in flight.
    assign phase_adv = (MODE == ARB_PHASED) && (state_q == IDLE) &&
                       bus.req_phase_done[phase_q] && !pend_q[phase_q] &&
                       (phase_q != IDX_W'(N_REQ - 1));

    assign pend_nxt  = (pend_q & ~(issue ? pick_oh : '0)) | cap;
    assign grant_nxt = issue ? pick_oh : (done ? '0 : grant_q);

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            strb_q    <= '0;
            pend_q    <= '0;
            busy_q    <= '0;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            phase_q   <= '0;
            cnt_q     <= '0;
            bus_rd_q  <= 1'b0;
            bus_wr_q  <= 1'b0;
            bus_a_q   <= '0;
            bus_din_q <= '0;
            slot_rd   <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_a[i] <= '0;
                slot_d[i] <= '0;
            end
        end else begin
            strb_q   <= strb;
            pend_q   <= pend_nxt;
            busy_q   <= pend_nxt | grant_nxt;
            grant_q  <= grant_nxt;
            cnt_q    <= cnt_nxt;
            bus_rd_q <= issue & slot_rd[pick_idx];
            bus_wr_q <= issue & ~slot_rd[pick_idx];
            for (int i = 0; i < N_REQ; i++) begin
                if (cap[i]) begin
                    slot_a[i]  <= bus.req_a[i*ADDR_W +: ADDR_W];
                    slot_d[i]  <= bus.req_din[i*DATA_W +: DATA_W];
                    slot_rd[i] <= bus.req_rd[i];
                end
            end
            if (issue) begin
                owner_q   <= pick_idx;
                bus_a_q   <= slot_a[pick_idx];
                bus_din_q <= slot_d[pick_idx];
            end
            if (MODE == ARB_RR && done) begin
                rr_q <= (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            if (phase_adv) begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    assign bus.req_busy = busy_q;
    assign bus.grant    = grant_q;
    assign bus.bus_a    = bus_a_q;
    assign bus.bus_din  = bus_din_q;
    assign bus.bus_rd   = bus_rd_q;
    assign bus.bus_wr   = bus_wr_q;
    assign bus.phase    = phase_q;

endmodule

// File: doc/cart_bus_arbiter.md
Name: cart_bus_arbiter

Overview:
Parametrised N-requester arbiter for the shared cart_iface ROM/RAM port (addr/rd/wr/din/dout/busy). It replaces the fixed combinational startup/splash/spicart select with a registered arbiter. The arbiter latches strobes, locks ownership for a whole transaction, and returns per-requester busy. It supports three modes: phased handoff, fixed priority and round-robin. It sits between the startup, splash and SPI clients and cart_iface_impl.

Parameters:
N_REQ, 3, number of requesters (2..8); index 0 is highest priority / first phase
ADDR_W, 16, address width
DATA_W, 8, write-data width
MODE, 0, 0 = phased handoff, 1 = fixed priority, 2 = round-robin
BUSY_TO, 15, cycles to wait for bus_busy to rise after an issue before abandoning (1..255)

Ports:
clk_8m  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_a  in  N_REQ*ADDR_W  per-requester address, slice i = requester i
req_din  in  N_REQ*DATA_W  per-requester write data
req_rd  in  N_REQ  one-cycle read strobe per requester
req_wr  in  N_REQ  one-cycle write strobe per requester
req_phase_done  in  N_REQ  level; requester i has finished its phase (MODE 0 only)
req_busy  out  N_REQ  requester i has a pending or in-flight transaction
grant  out  N_REQ  one-hot current owner, or 0
bus_a  out  ADDR_W  to cart_iface addr
bus_din  out  DATA_W  to cart_iface din
bus_rd  out  1  one-cycle read strobe to cart_iface
bus_wr  out  1  one-cycle write strobe to cart_iface
bus_busy  in  1  cart_iface busy
phase  out  clog2(N_REQ)  current phase index (MODE 0); 0 otherwise

Behaviour:
- Reset (async, rst_n low): state IDLE; all pending bits 0; grant=0; req_busy=0; bus_rd=bus_wr=0; bus_a=0; bus_din=0; phase=0; rr pointer=0.
- Strobe capture: when req_rd[i] or req_wr[i] rises, set pending[i] and latch addr, din and type (rd if both are set) into slot i. Capture happens in every state.
- A strobe from requester i while pending[i]=1 is ignored (protocol error); the first request is kept.
- req_busy[i] = pending[i] OR (state != IDLE and owner==i). It is registered and goes high the cycle after the strobe.
- Eligibility:
  - MODE 0: only i==phase is eligible. phase advances by 1 when req_phase_done[phase]=1 and state==IDLE and pending[phase]=0.
  - MODE 0: phase saturates at N_REQ-1. Pending bits of non-current phases are held until their phase arrives.
  - MODE 1: lowest index wins.
  - MODE 2: first pending index at or after the rr pointer wins; the pointer becomes owner+1 (mod N_REQ) on completion.
- FSM:
  - IDLE: if any eligible requester is pending, set owner and grant. Drive bus_a/bus_din from the slot and pulse bus_rd or bus_wr for exactly 1 cycle. Clear pending[owner]. Go to WAIT_HI with the timeout counter at 0.
  - WAIT_HI: bus_busy=1 goes to WAIT_LO. If the counter reaches BUSY_TO, go to IDLE (transaction treated as complete).
  - WAIT_LO: bus_busy=0 goes to IDLE. grant drops in the same cycle state returns to IDLE.
- bus_a/bus_din stay stable from the issue cycle until leaving WAIT_LO. Issue latency is 2 cycles from requester strobe to bus strobe.
- Back-to-back: a new issue may occur in the IDLE cycle that follows WAIT_LO, so there is one idle cycle minimum between bus strobes.
- Ownership is never pre-empted mid-transaction. A higher-priority strobe during WAIT_* is only latched.
- A strobe arriving in the same cycle its owner's completion is detected is captured as a new pending request.

Decomposition:
- Shared package cart_bus_pkg: MODE encodings (ARB_PHASED, ARB_PRIO, ARB_RR) and state encoding (IDLE, WAIT_HI, WAIT_LO).
- One natural sub-module: cart_arb_pick. It is combinational: pending, eligible mask and rr pointer in, one-hot winner and index out. It is reused by all modes.

Test Plan:
- MODE 0, N_REQ=3: req 1 strobes rd at 0x0104 during phase 0 -> no bus_rd, req_busy[1]=1. Raise req_phase_done[0] -> phase=1, bus_rd pulses with bus_a=0x0104 two cycles later.
- MODE 1: req 2 and req 0 strobe in the same cycle -> req 0 issues first. req 2 issues in the IDLE cycle after bus_busy falls.
- MODE 2: all three requesters strobe repeatedly -> grant order 0,1,2,0,1,2 and no requester starved.
- Write path: req 1 wr, addr 0x2000, din 0xA5 -> bus_wr for 1 cycle. bus_a/bus_din hold 0x2000/0xA5 until bus_busy falls.
- Timeout, BUSY_TO=15: bus_busy held 0 after issue -> state returns to IDLE after 15 cycles in WAIT_HI and req_busy clears.
- rst_n asserted during WAIT_LO -> all outputs 0 immediately (async). After release, a stale bus_busy=1 causes no issue and no grant.
